// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC datapath.
// Opcode encodings and default widths.
package cpu_pkg;

  localparam int CPU_AWIDTH = 5;
  localparam int CPU_DWIDTH = 8;
  localparam int OP_W       = 3;

  localparam logic [OP_W-1:0] OP_HLT = 3'h0;
  localparam logic [OP_W-1:0] OP_SKZ = 3'h1;
  localparam logic [OP_W-1:0] OP_ADD = 3'h2;
  localparam logic [OP_W-1:0] OP_AND = 3'h3;
  localparam logic [OP_W-1:0] OP_XOR = 3'h4;
  localparam logic [OP_W-1:0] OP_LDA = 3'h5;
  localparam logic [OP_W-1:0] OP_STO = 3'h6;
  localparam logic [OP_W-1:0] OP_JMP = 3'h7;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A is the accumulator, B the memory word.
// Opcodes without an arithmetic role pass A through.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DWIDTH = CPU_DWIDTH
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [DWIDTH-1:0] result
);

  // Select the result by opcode; carry out of ADD is dropped.
  always_comb begin
    result = a;
    unique case (opcode)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_LDA:  result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// IR, PC and AC registers plus address mux for the RISC core.
// Feeds opcode/zero back to the controller.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int AWIDTH = CPU_AWIDTH,
  parameter int DWIDTH = CPU_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              sel,
  input  logic              data_e,
  input  logic              halt,
  input  logic [DWIDTH-1:0] data_in,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic [OP_W-1:0]   opcode,
  output logic              zero,
  output logic              halted
);

  if (DWIDTH != OP_W + AWIDTH) begin : g_width_err
    $error("cpu_datapath: DWIDTH must equal 3+AWIDTH");
  end

  logic [DWIDTH-1:0] ir;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ac;
  logic [DWIDTH-1:0] alu_out;
  logic [AWIDTH-1:0] operand;

  assign opcode  = ir[DWIDTH-1:AWIDTH];
  assign operand = ir[AWIDTH-1:0];

  cpu_alu #(
    .DWIDTH(DWIDTH)
  ) u_alu (
    .a     (ac),
    .b     (data_in),
    .opcode(opcode),
    .result(alu_out)
  );

  // Architectural registers; reset line is active-high here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ir     <= '0;
      pc     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else if (halt) begin
      halted <= 1'b1;
    end else begin
      if (ld_ir) ir <= data_in;
      if (ld_ac) ac <= alu_out;
      if (ld_pc) pc <= operand;
      else if (inc_pc) pc <= pc + AWIDTH'(1);
    end
  end

  assign addr     = sel ? pc : operand;
  assign data_out = ac;
  assign data_oe  = data_e;
  assign zero     = (ac == '0);

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized and directed bench for cpu_datapath.
// Uses an arithmetic reference model of IR/PC/AC.
module tb_cpu_datapath;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_ir, ld_ac, ld_pc, inc_pc;
  logic          sel, data_e, halt;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [2:0]    opcode;
  logic          zero;
  logic          halted;

  int n_chk  = 0;
  int n_fail = 0;

  int m_ir, m_pc, m_ac;
  bit m_halted;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_ir   (ld_ir),
    .ld_ac   (ld_ac),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .sel     (sel),
    .data_e  (data_e),
    .halt    (halt),
    .data_in (data_in),
    .addr    (addr),
    .data_out(data_out),
    .data_oe (data_oe),
    .opcode  (opcode),
    .zero    (zero),
    .halted  (halted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int alu(input int op, input int a, input int b);
    case (op)
      2:       return (a + b) % 256;
      3:       return a & b;
      4:       return a ^ b;
      5:       return b;
      default: return a;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".addr"}, addr, sel ? m_pc : m_ir % 32);
    check({tag, ".ac"}, data_out, m_ac);
    check({tag, ".op"}, opcode, m_ir / 32);
    check({tag, ".zero"}, zero, (m_ac == 0) ? 1 : 0);
    check({tag, ".halted"}, halted, m_halted);
    check({tag, ".oe"}, data_oe, data_e);
  endtask

  task automatic model_reset();
    m_ir = 0;
    m_pc = 0;
    m_ac = 0;
    m_halted = 0;
  endtask

  task automatic cyc(input bit i_ir, input bit i_ac, input bit i_pc,
                     input bit i_inc, input bit i_sel, input bit i_de,
                     input bit i_halt, input int din);
    int n_ir, n_pc, n_ac;
    ld_ir   = i_ir;
    ld_ac   = i_ac;
    ld_pc   = i_pc;
    inc_pc  = i_inc;
    sel     = i_sel;
    data_e  = i_de;
    halt    = i_halt;
    data_in = din[DW-1:0];
    @(posedge clk);
    if (i_halt) begin
      m_halted = 1;
    end else begin
      n_ir = i_ir ? din : m_ir;
      n_ac = i_ac ? alu(m_ir / 32, m_ac, din) : m_ac;
      n_pc = i_pc ? m_ir % 32 : (i_inc ? (m_pc + 1) % 32 : m_pc);
      m_ir = n_ir;
      m_ac = n_ac;
      m_pc = n_pc;
    end
    #1;
  endtask

  task automatic set_ac(input int v);
    cyc(1, 0, 0, 0, 1, 0, 0, 8'hA0);
    cyc(0, 1, 0, 0, 1, 0, 0, v);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b1;
    #1 model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    ld_ir   = 0; ld_ac = 0; ld_pc = 0; inc_pc = 0;
    sel     = 1; data_e = 0; halt = 0;
    data_in = '0;
    model_reset();
    #12;
    check_all("por");
    check("por.zero_c", zero, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;

    // Reset mid-cycle with PC=7, AC=3C
    cyc(1, 0, 0, 0, 1, 0, 0, 8'hA7);
    cyc(0, 1, 1, 0, 1, 0, 0, 8'h3C);
    check("pre_rst.pc", addr, 7);
    check("pre_rst.ac", data_out, 8'h3C);
    @(negedge clk);
    async_reset();
    check("rst.pc", addr, 0);
    check("rst.ac", data_out, 0);

    // ADD with carry dropped
    set_ac(8'hF0);
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h45);
    check("add.op", opcode, 2);
    check("add.addr", addr, 5);
    check_all("add.fetch");
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h20);
    check("add.ac", data_out, 8'h10);
    check("add.zero", zero, 0);

    // PC wrap and ld_pc priority
    cyc(1, 0, 0, 0, 1, 0, 0, 8'hBF);
    cyc(0, 0, 1, 0, 1, 0, 0, 0);
    check("pc31", addr, 31);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    check("pc.wrap", addr, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 8'hE9);
    cyc(0, 0, 1, 1, 1, 0, 0, 0);
    check("pc.jmp", addr, 9);
    check_all("pc.jmp");

    // ALU ops with AC=AA, B=0F
    for (int op = 0; op < 8; op++) begin
      set_ac(8'hAA);
      cyc(1, 0, 0, 0, 1, 0, 0, op * 32);
      cyc(0, 1, 0, 0, 1, 0, 0, 8'h0F);
      check_all($sformatf("alu%0d", op));
      case (op)
        3:       check("alu.and", data_out, 8'h0A);
        4:       check("alu.xor", data_out, 8'hA5);
        5:       check("alu.lda", data_out, 8'h0F);
        2:       check("alu.add", data_out, 8'hB9);
        default: check("alu.pass", data_out, 8'hAA);
      endcase
    end
    set_ac(8'h00);
    check("lda0.zero", zero, 1);

    // Store drive enable
    set_ac(8'h5A);
    cyc(1, 0, 0, 0, 0, 1, 0, 8'hC0);
    check("sto.data", data_out, 8'h5A);
    check("sto.oe", data_oe, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("sto.oe0", data_oe, 0);

    // Halt freezes registers, halted sticks until reset
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 0, 1, 8'h33);
    check_all("halt");
    check("halt.flag", halted, 1);
    check("halt.ac", data_out, 8'h5A);
    check("halt.op", opcode, 6);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    check("halt.sticky", halted, 1);
    @(negedge clk);
    async_reset();
    check("halt.clr", halted, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        async_reset();
      end else begin
        cyc($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 19) == 0, $urandom_range(0, 255));
        check_all("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath stage directly downstream of the 8-bit RISC controller. It consumes the controller strobes (ld_ir, ld_ac, ld_pc, inc_pc, sel, data_e, halt) and holds the instruction register (IR), program counter (PC), accumulator (AC), ALU and address mux.
- It feeds opcode and zero back to the controller.
- It drives the address and write data to the single-port instruction/data memory.

Parameters:
- AWIDTH, 5, address width (PC and IR operand field).
- DWIDTH, 8, data width. Must equal 3+AWIDTH; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset: asynchronous, active-high (asserted when rst_n=1)
- ld_ir  input  1  load IR from data_in
- ld_ac  input  1  load AC from ALU result
- ld_pc  input  1  load PC from IR operand
- inc_pc  input  1  increment PC
- sel  input  1  address select: 1=PC, 0=IR operand
- data_e  input  1  enable write data onto the memory bus
- halt  input  1  freeze all datapath registers
- data_in  input  DWIDTH  memory read data
- addr  output  AWIDTH  memory address
- data_out  output  DWIDTH  write data (AC value)
- data_oe  output  1  write-data valid/drive enable
- opcode  output  3  IR[DWIDTH-1:AWIDTH], to the controller
- zero  output  1  AC==0, to the controller
- halted  output  1  registered halt status

Behaviour:
- Reset (rst_n=1, asynchronous):
  - IR=0, PC=0, AC=0, halted=0.
  - Resulting outputs: opcode=0 (HLT), zero=1, addr=0 (sel-dependent, both sources 0), data_oe=0.
- All registers update on the rising clk edge while rst_n=0 and halt=0.
- halt=1 at an edge: IR, PC and AC hold, and halted sets to 1. halted clears only on reset.
- IR: at the edge with ld_ir=1, IR<=data_in. Latency 1 clk; opcode and operand are valid the cycle after.
- PC (AWIDTH bits):
  - ld_pc=1: PC<=IR[AWIDTH-1:0].
  - else inc_pc=1: PC<=PC+1, wrapping 2^AWIDTH-1 -> 0.
  - ld_pc has priority when both are asserted.
- AC: at the edge with ld_ac=1, AC<=alu_out.
- ALU (combinational, operand A=AC, B=data_in, selected by opcode):
  - 0 HLT: A
  - 1 SKZ: A
  - 2 ADD: (A+B) mod 2^DWIDTH; carry discarded
  - 3 AND: A&B
  - 4 XOR: A^B
  - 5 LDA: B
  - 6 STO: A
  - 7 JMP: A
- zero: combinational from the AC register, not from alu_out.
- addr = sel ? PC : IR[AWIDTH-1:0]. Combinational, no added latency.
- data_out = AC at all times. data_oe = data_e (combinational).
- Simultaneous ld_ir and ld_ac: AC uses the pre-edge opcode (old IR). Both registers update.
- Reset asserted mid-instruction: immediate clear regardless of clk. Fetch restarts from address 0 after release.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_HLT..OP_JMP (3'h0..3'h7);
  - AWIDTH/DWIDTH defaults;
  - the 3-bit opcode width.
- One sub-module, cpu_alu: combinational, ports a, b, opcode, result. Shared with any future ALU bench.
- Registers and address mux stay in cpu_datapath.

Test Plan:
- Reset: drive rst_n=1 mid-cycle with PC=7 and AC=8'h3C -> immediate PC=0, AC=0, zero=1, opcode=0, halted=0.
- Fetch/execute ADD:
  - data_in=8'h45 with ld_ir -> opcode=2, operand 5.
  - sel=0 -> addr=5.
  - AC=8'hF0, data_in=8'h20, ld_ac -> AC=8'h10, zero=0 (carry dropped).
- PC control:
  - PC=31 with inc_pc -> PC=0.
  - IR=8'hE9 (JMP 9) with ld_pc and inc_pc together -> PC=9.
- ALU ops with AC=8'hAA, data_in=8'h0F:
  - AND -> 8'h0A
  - XOR -> 8'hA5
  - LDA -> 8'h0F
  - STO/SKZ/HLT/JMP -> AC unchanged at 8'hAA
  - LDA of 8'h00 -> zero=1
- Store: opcode STO, AC=8'h5A, data_e=1 -> data_out=8'h5A, data_oe=1. data_e=0 -> data_oe=0.
- Halt: assert halt with ld_ac, ld_ir and inc_pc all high -> AC, IR and PC unchanged, halted=1 until rst_n=1.
